// File: rtl/commit_queue.sv
// Commit FIFO between writeback and the difftest commit port; filters bubbles and halts the core on a trap instruction.
// Latency: one cycle from enqueue to cmt_valid; wb_ready is registered state only and drops when full or draining.
module commit_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] PC_START = 64'h8000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wb_valid,
    input  logic [63:0] wb_pc,
    input  logic [31:0] wb_inst,
    input  logic        wb_rd_en,
    input  logic [4:0]  wb_rd_addr,
    input  logic [63:0] wb_wdata,
    input  logic [63:0] wb_a0,
    output logic        wb_ready,
    output logic        cmt_valid,
    input  logic        cmt_ready,
    output logic [63:0] cmt_pc,
    output logic [31:0] cmt_inst,
    output logic [63:0] cmt_wdata,
    output logic        cmt_wen,
    output logic [7:0]  cmt_wdest,
    output logic        trap_valid,
    output logic [7:0]  trap_code,
    output logic [63:0] trap_pc,
    output logic [63:0] cycle_cnt,
    output logic [63:0] instr_cnt
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    localparam logic [1:0] RUN   = 2'd0;
    localparam logic [1:0] DRAIN = 2'd1;
    localparam logic [1:0] HALT  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [7:0]    trap_code_q, trap_code_d;
    logic [63:0]   trap_pc_q, trap_pc_d;
    logic [63:0]   cycle_q, cycle_d;
    logic [63:0]   instr_q, instr_d;

    logic [63:0] pc_q    [DEPTH];
    logic [31:0] inst_q  [DEPTH];
    logic [63:0] wdata_q [DEPTH];
    logic        wen_q   [DEPTH];
    logic [4:0]  rd_q    [DEPTH];

    logic bubble, do_enq, do_deq, is_trap;
    logic unused_a0_hi;

    assign unused_a0_hi = ^wb_a0[63:8];

    assign wb_ready  = (state_q == RUN) && (count_q < CW'(DEPTH));
    assign cmt_valid = (count_q != '0) && (state_q != HALT);
    // Bubbles are handshaken so writeback never stalls on them, but they never reach the queue.
    assign bubble    = (wb_pc == 64'd0) || ((wb_pc == PC_START) && (wb_inst == 32'd0));
    assign do_enq    = wb_valid && wb_ready && !bubble;
    assign do_deq    = cmt_valid && cmt_ready;
    assign is_trap   = (wb_inst[6:0] == 7'h6b);

    assign cmt_pc     = cmt_valid ? pc_q[rd_ptr_q]    : 64'd0;
    assign cmt_inst   = cmt_valid ? inst_q[rd_ptr_q]  : 32'd0;
    assign cmt_wdata  = cmt_valid ? wdata_q[rd_ptr_q] : 64'd0;
    assign cmt_wen    = cmt_valid && wen_q[rd_ptr_q];
    assign cmt_wdest  = cmt_valid ? {3'b000, rd_q[rd_ptr_q]} : 8'd0;
    assign trap_valid = (state_q == HALT);
    assign trap_code  = trap_code_q;
    assign trap_pc    = trap_pc_q;
    assign cycle_cnt  = cycle_q;
    assign instr_cnt  = instr_q;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        trap_code_d = trap_code_q;
        trap_pc_d   = trap_pc_q;
        cycle_d     = (state_q != HALT) ? cycle_q + 64'd1 : cycle_q;
        instr_d     = do_deq ? instr_q + 64'd1 : instr_q;

        if (do_enq) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            if (is_trap) begin
                state_d     = DRAIN;
                trap_code_d = wb_a0[7:0];
                trap_pc_d   = wb_pc;
            end
        end
        if (do_deq) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            // Nothing enqueues behind the trap, so the last entry out of DRAIN is the trap itself.
            if ((state_q == DRAIN) && (count_q == CW'(1))) begin
                state_d = HALT;
            end
        end
        case ({do_enq, do_deq})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= RUN;
            count_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            trap_code_q <= 8'd0;
            trap_pc_q   <= 64'd0;
            cycle_q     <= 64'd0;
            instr_q     <= 64'd0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            trap_code_q <= trap_code_d;
            trap_pc_q   <= trap_pc_d;
            cycle_q     <= cycle_d;
            instr_q     <= instr_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_enq) begin
            pc_q[wr_ptr_q]    <= wb_pc;
            inst_q[wr_ptr_q]  <= wb_inst;
            wdata_q[wr_ptr_q] <= wb_wdata;
            wen_q[wr_ptr_q]   <= wb_rd_en && (wb_rd_addr != 5'd0);
            rd_q[wr_ptr_q]    <= wb_rd_addr;
        end
    end
endmodule

// File: tb/tb_commit_queue.sv
// Randomised and directed bench for commit_queue against a queue-based reference model.
module tb_commit_queue;
    localparam int          DEPTH    = 4;
    localparam logic [63:0] PC_START = 64'h8000_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic        wb_valid;
    logic [63:0] wb_pc;
    logic [31:0] wb_inst;
    logic        wb_rd_en;
    logic [4:0]  wb_rd_addr;
    logic [63:0] wb_wdata;
    logic [63:0] wb_a0;
    logic        wb_ready;
    logic        cmt_valid;
    logic        cmt_ready;
    logic [63:0] cmt_pc;
    logic [31:0] cmt_inst;
    logic [63:0] cmt_wdata;
    logic        cmt_wen;
    logic [7:0]  cmt_wdest;
    logic        trap_valid;
    logic [7:0]  trap_code;
    logic [63:0] trap_pc;
    logic [63:0] cycle_cnt;
    logic [63:0] instr_cnt;

    always #5 clock = ~clock;

    commit_queue #(.DEPTH(DEPTH), .PC_START(PC_START)) dut (
        .clock(clock), .reset(reset),
        .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_inst(wb_inst), .wb_rd_en(wb_rd_en),
        .wb_rd_addr(wb_rd_addr), .wb_wdata(wb_wdata), .wb_a0(wb_a0), .wb_ready(wb_ready),
        .cmt_valid(cmt_valid), .cmt_ready(cmt_ready), .cmt_pc(cmt_pc), .cmt_inst(cmt_inst),
        .cmt_wdata(cmt_wdata), .cmt_wen(cmt_wen), .cmt_wdest(cmt_wdest),
        .trap_valid(trap_valid), .trap_code(trap_code), .trap_pc(trap_pc),
        .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
    );

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
        logic [63:0] wdata;
        logic        wen;
        logic [7:0]  wdest;
    } ent_t;

    ent_t        q[$];
    bit          m_drain, m_halt;
    logic [63:0] m_cyc, m_instr, m_tpc;
    logic [7:0]  m_tcode;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic model_reset();
        q.delete();
        m_drain = 0; m_halt = 0;
        m_cyc = 0; m_instr = 0; m_tpc = 0; m_tcode = 0;
    endtask

    function automatic bit m_ready();
        return !m_drain && !m_halt && (q.size() < DEPTH);
    endfunction

    // Applies one clock edge to the model from the currently driven inputs, then steps the DUT to the next negedge.
    task automatic advance();
        bit   halt0, rdy, bub;
        ent_t e;
        halt0 = m_halt;
        rdy   = m_ready();
        bub   = (wb_pc == 64'd0) || (wb_pc == PC_START && wb_inst == 32'd0);
        if (q.size() != 0 && !m_halt && cmt_ready) begin
            void'(q.pop_front());
            m_instr++;
            if (m_drain && q.size() == 0) begin m_drain = 0; m_halt = 1; end
        end
        if (wb_valid && rdy && !bub) begin
            e.pc = wb_pc; e.inst = wb_inst; e.wdata = wb_wdata;
            e.wen = wb_rd_en && (wb_rd_addr != 0);
            e.wdest = {3'b000, wb_rd_addr};
            q.push_back(e);
            if (wb_inst[6:0] == 7'h6b) begin m_drain = 1; m_tcode = wb_a0[7:0]; m_tpc = wb_pc; end
        end
        if (!halt0) m_cyc++;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic offer(input logic v, input logic [63:0] pc, input logic [31:0] inst,
                         input logic ren, input logic [4:0] rd, input logic [63:0] wd, input logic [63:0] a0);
        wb_valid = v; wb_pc = pc; wb_inst = inst; wb_rd_en = ren;
        wb_rd_addr = rd; wb_wdata = wd; wb_a0 = a0;
    endtask

    task automatic do_reset();
        offer(0, 0, 0, 0, 0, 0, 0);
        cmt_ready = 0;
        reset = 1;
        @(posedge clock);
        @(negedge clock);
        reset = 0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_tests++; if (wb_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wb_ready got %b want 1", wb_ready); end
        n_tests++; if (cmt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_cmt_valid got %b want 0", cmt_valid); end
        n_tests++; if (trap_valid !== 1'b0 || trap_code !== 8'd0 || trap_pc !== 64'd0) begin
            n_fail++; $display("FAIL reset_trap got %b/%h/%h want 0", trap_valid, trap_code, trap_pc); end
        n_tests++; if (cycle_cnt !== 64'd0 || instr_cnt !== 64'd0) begin
            n_fail++; $display("FAIL reset_counters got %0d/%0d want 0/0", cycle_cnt, instr_cnt); end
        n_tests++; if (cmt_pc !== 64'd0 || cmt_wen !== 1'b0 || cmt_wdest !== 8'd0) begin
            n_fail++; $display("FAIL reset_cmt_fields got %h/%b/%h want 0", cmt_pc, cmt_wen, cmt_wdest); end
    endtask

    task automatic test_back_to_back();
        int seen;
        do_reset();
        cmt_ready = 1;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            if (c < 3) offer(1, PC_START + 64'(4 * c), 32'h0000_0013, 1, 5'(c + 1), 64'(c), 0);
            else       offer(0, 0, 0, 0, 0, 0, 0);
            #1;
            n_tests++; if (cmt_valid !== (q.size() != 0)) begin
                n_fail++; $display("FAIL b2b_valid c=%0d got %b want %b", c, cmt_valid, q.size() != 0); end
            if (cmt_valid && cmt_ready) begin
                n_tests++; if (cmt_pc !== PC_START + 64'(4 * seen)) begin
                    n_fail++; $display("FAIL b2b_order got %h want %h", cmt_pc, PC_START + 64'(4 * seen)); end
                seen++;
            end
            advance();
        end
        n_tests++; if (seen != 3 || instr_cnt !== 64'd3) begin
            n_fail++; $display("FAIL b2b_count got %0d/%0d want 3/3", seen, instr_cnt); end
    endtask

    task automatic test_backpressure();
        int idx, seen;
        do_reset();
        idx = 0;
        for (int c = 0; c < 8; c++) begin
            offer(idx < 5, PC_START + 64'h100 + 64'(4 * idx), 32'h0010_0093, 1, 5'd1, 64'(idx), 0);
            #1;
            n_tests++; if (wb_ready !== m_ready()) begin
                n_fail++; $display("FAIL bp_wb_ready c=%0d got %b want %b", c, wb_ready, m_ready()); end
            if (wb_valid && wb_ready) idx++;
            advance();
        end
        n_tests++; if (idx != 4 || wb_ready !== 1'b0) begin
            n_fail++; $display("FAIL bp_full got idx=%0d rdy=%b want 4/0", idx, wb_ready); end
        cmt_ready = 1;
        seen = 0;
        for (int c = 0; c < 20 && seen < 5; c++) begin
            offer(idx < 5, PC_START + 64'h100 + 64'(4 * idx), 32'h0010_0093, 1, 5'd1, 64'(idx), 0);
            #1;
            if (cmt_valid) begin
                n_tests++; if (cmt_pc !== PC_START + 64'h100 + 64'(4 * seen) || cmt_wdata !== 64'(seen)) begin
                    n_fail++; $display("FAIL bp_order got %h/%0d want %h/%0d", cmt_pc, cmt_wdata,
                                       PC_START + 64'h100 + 64'(4 * seen), seen); end
                seen++;
            end
            if (wb_valid && wb_ready) idx++;
            advance();
        end
        n_tests++; if (seen != 5 || instr_cnt !== 64'd5) begin
            n_fail++; $display("FAIL bp_drain got %0d/%0d want 5/5", seen, instr_cnt); end
    endtask

    task automatic test_bubbles();
        int valids;
        do_reset();
        cmt_ready = 1;
        valids = 0;
        for (int c = 0; c < 6; c++) begin
            case (c)
                0:       offer(1, 64'd0, 32'h0000_0013, 1, 5'd3, 64'h11, 0);
                1:       offer(1, PC_START, 32'd0, 1, 5'd3, 64'h22, 0);
                2:       offer(1, PC_START + 64'd8, 32'h0000_0013, 1, 5'd3, 64'h33, 0);
                default: offer(0, 0, 0, 0, 0, 0, 0);
            endcase
            #1;
            if (c < 3) begin
                n_tests++; if (wb_ready !== 1'b1) begin n_fail++; $display("FAIL bub_ready c=%0d got %b want 1", c, wb_ready); end
            end
            if (cmt_valid) begin
                valids++;
                n_tests++; if (cmt_pc !== PC_START + 64'd8) begin
                    n_fail++; $display("FAIL bub_leak got %h want %h", cmt_pc, PC_START + 64'd8); end
            end
            advance();
        end
        n_tests++; if (valids != 1 || instr_cnt !== 64'd1) begin
            n_fail++; $display("FAIL bub_count got %0d/%0d want 1/1", valids, instr_cnt); end
    endtask

    task automatic test_wdest();
        do_reset();
        offer(1, PC_START + 64'h40, 32'h0000_0013, 1, 5'd0, 64'hAAAA, 0);
        advance();
        offer(1, PC_START + 64'h44, 32'h0000_0293, 1, 5'd5, 64'hBBBB, 0);
        advance();
        offer(0, 0, 0, 0, 0, 0, 0);
        cmt_ready = 1;
        #1;
        n_tests++; if (cmt_wen !== 1'b0 || cmt_wdest !== 8'h00) begin
            n_fail++; $display("FAIL wdest_x0 got %b/%h want 0/00", cmt_wen, cmt_wdest); end
        advance();
        #1;
        n_tests++; if (cmt_wen !== 1'b1 || cmt_wdest !== 8'h05 || cmt_wdata !== 64'hBBBB || cmt_inst !== 32'h0000_0293) begin
            n_fail++; $display("FAIL wdest_x5 got %b/%h/%h/%h want 1/05/bbbb/00000293", cmt_wen, cmt_wdest, cmt_wdata, cmt_inst); end
        advance();
    endtask

    task automatic test_random();
        logic [63:0] pc;
        logic [31:0] inst;
        int          kind;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            kind = $urandom_range(0, 7);
            inst = $urandom;
            if (inst[6:0] == 7'h6b) inst[0] = 1'b0;
            pc = PC_START + {30'd0, 32'($urandom), 2'b00};
            if (kind == 0) pc = 64'd0;
            if (kind == 1) begin pc = PC_START; inst = 32'd0; end
            offer($urandom_range(0, 3) != 0, pc, inst, 1'($urandom), 5'($urandom),
                  {32'($urandom), 32'($urandom)}, 64'($urandom));
            cmt_ready = $urandom_range(0, 3) != 0;
            #1;
            n_tests++; if (wb_ready !== m_ready() || cmt_valid !== (q.size() != 0)) begin
                n_fail++; $display("FAIL rnd_hs c=%0d got %b/%b want %b/%b", c, wb_ready, cmt_valid, m_ready(), q.size() != 0); end
            if (q.size() != 0) begin
                n_tests++; if (cmt_pc !== q[0].pc || cmt_inst !== q[0].inst || cmt_wdata !== q[0].wdata
                               || cmt_wen !== q[0].wen || cmt_wdest !== q[0].wdest) begin
                    n_fail++; $display("FAIL rnd_head c=%0d got %h/%h/%h/%b/%h want %h/%h/%h/%b/%h", c,
                                       cmt_pc, cmt_inst, cmt_wdata, cmt_wen, cmt_wdest,
                                       q[0].pc, q[0].inst, q[0].wdata, q[0].wen, q[0].wdest); end
            end
            n_tests++; if (cycle_cnt !== m_cyc || instr_cnt !== m_instr || trap_valid !== 1'b0) begin
                n_fail++; $display("FAIL rnd_cnt c=%0d got %0d/%0d/%b want %0d/%0d/0", c, cycle_cnt, instr_cnt, trap_valid, m_cyc, m_instr); end
            advance();
        end
    endtask

    task automatic test_trap();
        int          deq;
        logic [63:0] cyc0;
        do_reset();
        offer(1, PC_START, 32'h0000_0013, 1, 5'd1, 64'h1, 0);
        advance();
        offer(1, PC_START + 64'd4, 32'h0000_0013, 1, 5'd2, 64'h2, 0);
        advance();
        offer(1, 64'h8000_0010, 32'h0000_006b, 0, 5'd0, 64'h0, 64'h1FF);
        advance();
        offer(1, PC_START + 64'h20, 32'h0000_0013, 1, 5'd3, 64'h3, 0);
        #1;
        n_tests++; if (wb_ready !== 1'b0) begin n_fail++; $display("FAIL trap_drain_ready got %b want 0", wb_ready); end
        cmt_ready = 1;
        deq = 0;
        for (int c = 0; c < 10 && !trap_valid; c++) begin
            #1;
            n_tests++; if (wb_ready !== 1'b0) begin n_fail++; $display("FAIL trap_ready c=%0d got %b want 0", c, wb_ready); end
            if (cmt_valid && cmt_ready) deq++;
            advance();
        end
        #1;
        n_tests++; if (deq != 3 || instr_cnt !== 64'd3) begin
            n_fail++; $display("FAIL trap_deq got %0d/%0d want 3/3", deq, instr_cnt); end
        n_tests++; if (trap_valid !== 1'b1 || trap_code !== 8'hFF || trap_pc !== 64'h8000_0010) begin
            n_fail++; $display("FAIL trap_info got %b/%h/%h want 1/ff/80000010", trap_valid, trap_code, trap_pc); end
        n_tests++; if (cmt_valid !== 1'b0 || trap_code !== m_tcode || trap_pc !== m_tpc || !m_halt) begin
            n_fail++; $display("FAIL trap_model got %b/%h/%h want 0/%h/%h", cmt_valid, trap_code, trap_pc, m_tcode, m_tpc); end
        cyc0 = cycle_cnt;
        for (int c = 0; c < 3; c++) advance();
        #1;
        n_tests++; if (cycle_cnt !== cyc0 || cycle_cnt !== m_cyc || trap_valid !== 1'b1 || wb_ready !== 1'b0) begin
            n_fail++; $display("FAIL trap_frozen got %0d/%b/%b want %0d/1/0", cycle_cnt, trap_valid, wb_ready, m_cyc); end
    endtask

    task automatic test_reset_in_drain();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            offer(1, PC_START + 64'(4 * i), 32'h0000_0013, 1, 5'd1, 64'(i), 0);
            advance();
        end
        offer(1, PC_START + 64'hC, 32'h0000_006b, 0, 5'd0, 0, 64'h42);
        advance();
        offer(0, 0, 0, 0, 0, 0, 0);
        #1;
        n_tests++; if (wb_ready !== 1'b0 || cmt_valid !== 1'b1 || q.size() != DEPTH) begin
            n_fail++; $display("FAIL rid_full got %b/%b want 0/1", wb_ready, cmt_valid); end
        reset = 1;
        @(posedge clock);
        @(negedge clock);
        reset = 0;
        model_reset();
        #1;
        n_tests++; if (cmt_valid !== 1'b0 || trap_valid !== 1'b0 || wb_ready !== 1'b1) begin
            n_fail++; $display("FAIL rid_flags got %b/%b/%b want 0/0/1", cmt_valid, trap_valid, wb_ready); end
        n_tests++; if (cycle_cnt !== 64'd0 || instr_cnt !== 64'd0) begin
            n_fail++; $display("FAIL rid_counters got %0d/%0d want 0/0", cycle_cnt, instr_cnt); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_bubbles();
        test_wdest();
        test_random();
        test_trap();
        test_reset_in_drain();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
